// File: rtl/shift_issue_stage.sv
// shift_issue_stage: FIFO-buffered issue/retire stage around a combinational 8-bit shifter.
// Define SHIFT_CLAMP_EN to force a zero result for shift amounts 8..15.
module shift_issue_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [3:0] in_b,
  output logic [7:0] sh_a,
  output logic [3:0] sh_b,
  input  logic [7:0] sh_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_y,
  output logic       out_zero,
  output logic [7:0] out_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem_a [FIFO_DEPTH];
  logic [3:0] mem_b [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic full, empty, push, pop, out_free, out_load, iss_valid;
  logic [7:0] cap;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign empty = cnt == '0;
  assign in_ready = !full && !rst;
  assign push = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign out_load = iss_valid && out_free;
  assign pop = !empty && (!iss_valid || out_free);
`ifdef SHIFT_CLAMP_EN
  assign cap = sh_b[3] ? 8'h00 : sh_y;
`else
  assign cap = sh_y;
`endif
  always_ff @(posedge clk)
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      iss_valid <= 1'b0;
      sh_a <= 8'h00;
      sh_b <= 4'h0;
      out_valid <= 1'b0;
      out_y <= 8'h00;
      out_zero <= 1'b0;
      out_count <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) begin
        iss_valid <= 1'b1;
        sh_a <= mem_a[rd_ptr];
        sh_b <= mem_b[rd_ptr];
      end else if (out_load) iss_valid <= 1'b0;
      if (out_load) begin
        out_valid <= 1'b1;
        out_y <= cap;
        out_zero <= cap == 8'h00;
      end else if (out_ready) out_valid <= 1'b0;
      if (out_valid && out_ready) out_count <= out_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: directed and random checks of shift_issue_stage against a queue-based reference.
module tb_shift_issue_stage;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [7:0] in_a, sh_a, sh_y, out_y, out_count;
  logic [3:0] in_b, sh_b;
  int checks = 0, errors = 0, hs = 0, acc, hs0;
  logic pushed;
  logic [7:0] mcount = 8'h00;
  logic [7:0] q[$];

  shift_issue_stage #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .sh_a(sh_a), .sh_b(sh_b), .sh_y(sh_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_zero(out_zero), .out_count(out_count)
  );

  assign sh_y = sh_a << sh_b[2:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] a, input logic [3:0] b);
`ifdef SHIFT_CLAMP_EN
    if (b >= 4'd8) return 8'h00;
`endif
    return 8'((int'(a) * (1 << (int'(b) % 8))) % 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: decide handshakes at the falling edge, then advance past the rising edge.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    pushed = 1'b0;
    if (rst) begin
      q.delete();
      mcount = 8'h00;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("out_unexpected", out_valid, 0);
        else begin
          e = q.pop_front();
          chk("out_y", out_y, e);
          chk("out_zero", out_zero, e == 8'h00);
        end
        mcount = mcount + 8'd1;
        hs++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_shift(in_a, in_b));
        pushed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("out_count", out_count, mcount);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; in_a = 8'h00; in_b = 4'h0;
    step();
    chk("rst_in_ready", in_ready, 0);
    step();
    chk("rst_in_ready2", in_ready, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_out_y", out_y, 8'h00);
    chk("post_rst_sh_a", sh_a, 8'h00);
    chk("post_rst_sh_b", sh_b, 4'h0);
    step();
    chk("post_rst_no_push", out_valid, 0);

    // single op: latency of two edges after acceptance
    in_a = 8'h81; in_b = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("single_accept", pushed, 1);
    in_valid = 1'b0;
    chk("single_lat0", out_valid, 0);
    step();
    chk("single_lat1", out_valid, 0);
    step();
    chk("single_lat2", out_valid, 1);
    chk("single_y", out_y, 8'h02);
    chk("single_zero", out_zero, 0);
    step();
    chk("single_count", out_count, 8'd1);
    chk("single_done", out_valid, 0);

    // streaming: one result per cycle
    hs0 = hs; acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_a = 8'h01; in_b = 4'(i); in_valid = 1'b1;
      step();
      if (pushed) acc++;
    end
    in_valid = 1'b0;
    step(); step(); step();
    chk("stream_accepts", acc, 8);
    chk("stream_results", hs - hs0, 8);
    chk("stream_count", out_count, 8'd9);

    // backpressure: FIFO_DEPTH + 2 operations stored
    out_ready = 1'b0; acc = 0; hs0 = hs;
    for (int i = 0; i < 6; i++) begin
      in_a = 8'h10 + 8'(acc); in_b = 4'd0; in_valid = 1'b1;
      step();
      if (pushed) acc++;
    end
    chk("bp_accepted", acc, 4);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("bp_drained", hs - hs0, 4);
    chk("bp_queue_empty", q.size(), 0);

    // shift amount of 8..15
    in_a = 8'hFF; in_b = 4'd9; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
`ifdef SHIFT_CLAMP_EN
    chk("clamp_y", out_y, 8'h00);
    chk("clamp_zero", out_zero, 1);
`else
    chk("clamp_y", out_y, 8'hFE);
    chk("clamp_zero", out_zero, 0);
`endif
    step();

    // reset with operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = 8'h21 + 8'(i); in_b = 4'd0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_count", out_count, 8'd0);
    out_ready = 1'b1; hs0 = hs;
    for (int i = 0; i < 4; i++) step();
    chk("midrst_no_stale", hs - hs0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = 8'($urandom);
      in_b = 4'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("final_queue_empty", q.size(), 0);
    chk("final_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
